// File: rtl/sched_pkg.sv
// Shared definitions for the delayed-task wakeup block.
//   DEF_DEPTH / DEF_ID_W / DEF_TICK_W : default slot count, task-id width, tick width
//   slot_t                            : slot record {valid, id, wake} at default widths
//   state_t                           : scan FSM states
package sched_pkg;

  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ID_W   = 8;
  localparam int DEF_TICK_W = 32;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ID_W-1:0]   id;
    logic [DEF_TICK_W-1:0] wake;
  } slot_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_OFFER = 2'd2
  } state_t;

endpackage

// File: rtl/delay_wakeup_if.sv
// Resume handshake between the delay table and the ready-list manager.
//   resume_tasktimer_out : valid, a due task is offered
//   idtasktimer_out      : id of the offered task
//   resume_ready_in      : accept from the lists manager
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. Once valid is raised, valid and the id stay unchanged until
// that transfer; valid never depends combinationally on ready. Reset may drop
// valid without a transfer.
interface delay_wakeup_if
  import sched_pkg::*;
#(
  parameter int ID_W = DEF_ID_W
);
  logic            resume_tasktimer_out;
  logic [ID_W-1:0] idtasktimer_out;
  logic            resume_ready_in;

  modport master (
    output resume_tasktimer_out,
    output idtasktimer_out,
    input  resume_ready_in
  );

  modport slave (
    input  resume_tasktimer_out,
    input  idtasktimer_out,
    output resume_ready_in
  );
endinterface

// File: rtl/slot_finder.sv
// Combinational encoders over the slot table.
//   valid       : per-slot occupied flags
//   ids         : per-slot task ids
//   query_id    : id to look up
//   free_found  / free_idx  : lowest-index unoccupied slot
//   match_found / match_idx : lowest-index occupied slot holding query_id
module slot_finder
  import sched_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int ID_W  = DEF_ID_W
) (
  input  logic [DEPTH-1:0]           valid,
  input  logic [DEPTH-1:0][ID_W-1:0] ids,
  input  logic [ID_W-1:0]            query_id,
  output logic                       free_found,
  output logic [$clog2(DEPTH)-1:0]   free_idx,
  output logic                       match_found,
  output logic [$clog2(DEPTH)-1:0]   match_idx
);
  localparam int IDX_W = $clog2(DEPTH);

  // Walking downwards leaves the lowest matching index as the final value.
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (valid[i] && (ids[i] == query_id)) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/delay_wakeup.sv
// Delayed-task table with tick-driven wakeup scan.
//   aclk, aresetn   : clock, asynchronous active-low reset
//   tick_in         : scheduler tick; each rising edge requests one scan
//   tickval_in      : current system tick count
//   ins_dlylist_in  : insert/refresh idtask_in with delay valdelay_in
//   cancel_in       : remove idtask_in from the table
//   resume_if       : resume handshake (master side)
//   count_out       : occupied slots (registered)
//   full_out        : all slots occupied (registered)
//   overflow_out    : one-cycle pulse when an insert is dropped
//   state_dbg_out   : scan FSM state
module delay_wakeup
  import sched_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ID_W   = DEF_ID_W,
  parameter int TICK_W = DEF_TICK_W
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   tick_in,
  input  logic [TICK_W-1:0]      tickval_in,
  input  logic                   ins_dlylist_in,
  input  logic [ID_W-1:0]        idtask_in,
  input  logic [TICK_W-1:0]      valdelay_in,
  input  logic                   cancel_in,
  delay_wakeup_if.master         resume_if,
  output logic [$clog2(DEPTH):0] count_out,
  output logic                   full_out,
  output logic                   overflow_out,
  output state_t                 state_dbg_out
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]             slot_valid, slot_valid_nxt;
  logic [DEPTH-1:0][ID_W-1:0]   slot_id;
  logic [DEPTH-1:0][TICK_W-1:0] slot_wake;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic               tick_q, pending;
  logic [TICK_W-1:0]  tsnap;
  logic [ID_W-1:0]    id_out_q;

  logic               free_found, match_found;
  logic [IDX_W-1:0]   free_idx, match_idx;

  slot_finder #(.DEPTH(DEPTH), .ID_W(ID_W)) u_finder (
    .valid       (slot_valid),
    .ids         (slot_id),
    .query_id    (idtask_in),
    .free_found  (free_found),
    .free_idx    (free_idx),
    .match_found (match_found),
    .match_idx   (match_idx)
  );

  logic tick_rise;
  assign tick_rise = tick_in & ~tick_q;

  // Wrap-safe due test: (tsnap - wake) read as signed is non-negative.
  logic signed [TICK_W-1:0] age;
  logic                     slot_due;
  assign age      = tsnap - slot_wake[ptr];
  assign slot_due = slot_valid[ptr] && (age >= 0);

  // FSM: state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  logic ptr_last;
  assign ptr_last = (ptr == IDX_W'(DEPTH - 1));

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (tick_rise || pending) state_nxt = ST_SCAN;
      ST_SCAN:  if (slot_due)             state_nxt = ST_OFFER;
                else if (ptr_last)        state_nxt = ST_IDLE;
      ST_OFFER: if (resume_if.resume_ready_in)
                  state_nxt = ptr_last ? ST_IDLE : ST_SCAN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs / control strobes
  logic start_scan, take_slot, xfer, scan_step;
  always_comb begin
    start_scan = (state == ST_IDLE) && (tick_rise || pending);
    take_slot  = (state == ST_SCAN) && slot_due;
    xfer       = (state == ST_OFFER) && resume_if.resume_ready_in;
    scan_step  = ((state == ST_SCAN) && !slot_due && !ptr_last) ||
                 (xfer && !ptr_last);
  end

  assign resume_if.resume_tasktimer_out = (state == ST_OFFER);
  assign resume_if.idtasktimer_out      = id_out_q;
  assign state_dbg_out                  = state;

  // Scan bookkeeping
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr      <= '0;
      tick_q   <= 1'b0;
      pending  <= 1'b0;
      tsnap    <= '0;
      id_out_q <= '0;
    end else begin
      tick_q <= tick_in;
      if (tick_rise) tsnap <= tickval_in;
      // Edges arriving mid-scan collapse into one follow-up scan.
      if (tick_rise && (state != ST_IDLE)) pending <= 1'b1;
      else if (start_scan)                 pending <= 1'b0;
      if (start_scan)     ptr <= '0;
      else if (scan_step) ptr <= ptr + 1'b1;
      if (take_slot) id_out_q <= slot_id[ptr];
    end
  end

  // Table update. idtask_in is shared by insert and cancel, so a
  // simultaneous pair always names the same id and cancel wins.
  logic              ins_go, wr_en, ovf_nxt;
  logic [IDX_W-1:0]  wr_idx;
  logic [TICK_W-1:0] dly, wake_new;
  logic [CNT_W-1:0]  cnt_nxt;

  assign ins_go   = ins_dlylist_in && !cancel_in;
  assign dly      = (valdelay_in == '0) ? TICK_W'(1) : valdelay_in;
  assign wake_new = tickval_in + dly;

  always_comb begin
    slot_valid_nxt = slot_valid;
    wr_en          = 1'b0;
    wr_idx         = '0;
    ovf_nxt        = 1'b0;
    if (take_slot) slot_valid_nxt[ptr] = 1'b0;
    if (cancel_in && match_found) slot_valid_nxt[match_idx] = 1'b0;
    if (ins_go) begin
      if (match_found) begin
        wr_en  = 1'b1;
        wr_idx = match_idx;
      end else if (free_found) begin
        wr_en  = 1'b1;
        wr_idx = free_idx;
      end else begin
        ovf_nxt = 1'b1;
      end
    end
    // A refresh of the slot being resumed re-arms it with the new wake.
    if (wr_en) slot_valid_nxt[wr_idx] = 1'b1;
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + CNT_W'(slot_valid_nxt[i]);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      slot_valid   <= '0;
      count_out    <= '0;
      full_out     <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      slot_valid   <= slot_valid_nxt;
      count_out    <= cnt_nxt;
      full_out     <= (cnt_nxt == CNT_W'(DEPTH));
      overflow_out <= ovf_nxt;
    end
  end

  // Payload is qualified by slot_valid, so it needs no reset.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      slot_id[wr_idx]   <= idtask_in;
      slot_wake[wr_idx] <= wake_new;
    end
  end
endmodule

// File: tb/tb_delay_wakeup.sv
module tb_delay_wakeup;
  import sched_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ID_W   = 8;
  localparam int TICK_W = 32;

  // Clock / reset
  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic              tick_in  = 1'b0;
  logic [TICK_W-1:0] tickval  = '0;
  logic              ins      = 1'b0;
  logic              cancel   = 1'b0;
  logic [ID_W-1:0]   idtask   = '0;
  logic [TICK_W-1:0] valdelay = '0;
  logic [4:0]        count_out;
  logic              full_out, overflow_out;
  state_t            state_dbg;

  delay_wakeup_if #(.ID_W(ID_W)) rif ();

  delay_wakeup #(.DEPTH(DEPTH), .ID_W(ID_W), .TICK_W(TICK_W)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .tick_in        (tick_in),
    .tickval_in     (tickval),
    .ins_dlylist_in (ins),
    .idtask_in      (idtask),
    .valdelay_in    (valdelay),
    .cancel_in      (cancel),
    .resume_if      (rif),
    .count_out      (count_out),
    .full_out       (full_out),
    .overflow_out   (overflow_out),
    .state_dbg_out  (state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int ovf_pulses = 0;
  logic [ID_W-1:0] exp_q[$];
  logic [ID_W-1:0] exp_id;
  logic            held_v  = 1'b0;
  logic [ID_W-1:0] held_id = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted resume pops the expected queue.
  always @(negedge aclk) begin
    if (!aresetn) begin
      held_v = 1'b0;
    end else begin
      if (overflow_out) ovf_pulses++;
      if (rif.resume_tasktimer_out) begin
        if (held_v) check("resume_id_stable", 32'(rif.idtasktimer_out), 32'(held_id));
        if (rif.resume_ready_in) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_resume: got id %0d expected none", rif.idtasktimer_out);
          end else begin
            exp_id = exp_q.pop_front();
            check("resume_id", 32'(rif.idtasktimer_out), 32'(exp_id));
          end
          held_v = 1'b0;
        end else begin
          held_v  = 1'b1;
          held_id = rif.idtasktimer_out;
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  // Driver tasks: inputs change 2ns after a rising edge.
  task automatic cyc();
    @(posedge aclk);
    #2;
  endtask

  task automatic drive_op(input int op, input logic [ID_W-1:0] id, input logic [TICK_W-1:0] d);
    cyc();
    ins      = (op == 0) || (op == 2);
    cancel   = (op == 1) || (op == 2);
    idtask   = id;
    valdelay = d;
    cyc();
    ins    = 1'b0;
    cancel = 1'b0;
    @(negedge aclk);
  endtask

  task automatic do_tick(input logic [TICK_W-1:0] tv);
    cyc();
    tickval = tv;
    tick_in = 1'b1;
    cyc();
    tick_in = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    @(negedge aclk);
    while ((state_dbg != ST_IDLE) && (n < budget)) begin
      @(negedge aclk);
      n++;
    end
    check(name, 32'(state_dbg == ST_IDLE), 32'd1);
  endtask

  typedef struct {
    int op;       // 0 insert, 1 cancel, 2 insert+cancel
    int id;
    int dly;
    int exp_cnt;
    int exp_full;
    int exp_ovf;
  } vec_t;

  vec_t vecs[20];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rif.resume_ready_in = 1'b1;

    // Reset state
    repeat (3) @(negedge aclk);
    check("rst_valid", 32'(rif.resume_tasktimer_out), 32'd0);
    check("rst_id", 32'(rif.idtasktimer_out), 32'd0);
    check("rst_count", 32'(count_out), 32'd0);
    check("rst_full", 32'(full_out), 32'd0);
    check("rst_ovf", 32'(overflow_out), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    cyc();
    aresetn = 1'b1;

    // Basic expiry: wake = 105
    cyc(); tickval = 100;
    drive_op(0, 8'd3, 32'd5);
    check("b_count_ins", 32'(count_out), 32'd1);
    do_tick(104);
    wait_idle("b_scan104_done", 64);
    check("b_count_104", 32'(count_out), 32'd1);
    exp_q.push_back(8'd3);
    do_tick(105);
    wait_idle("b_scan105_latency", DEPTH + 2);
    check("b_q_empty", 32'(exp_q.size()), 32'd0);
    check("b_count_end", 32'(count_out), 32'd0);

    // Delay 0 behaves as delay 1
    cyc(); tickval = 200;
    drive_op(0, 8'd11, 32'd0);
    do_tick(200);
    wait_idle("z_scan200_done", 64);
    check("z_count_200", 32'(count_out), 32'd1);
    exp_q.push_back(8'd11);
    do_tick(201);
    wait_idle("z_scan201_done", 64);
    check("z_q_empty", 32'(exp_q.size()), 32'd0);

    // Table: cancel corner cases, fill to full, overflow, refresh while full
    vecs[0] = '{2, 6, 5, 0, 0, 0};
    vecs[1] = '{1, 99, 0, 0, 0, 0};
    for (int i = 0; i < 16; i++) vecs[2+i] = '{0, 20 + i, 50, i + 1, (i == 15) ? 1 : 0, 0};
    vecs[18] = '{0, 36, 50, 16, 1, 1};
    vecs[19] = '{0, 20, 60, 16, 1, 0};
    cyc(); tickval = 1000;
    ovf_pulses = 0;
    for (int v = 0; v < 20; v++) begin
      drive_op(vecs[v].op, ID_W'(vecs[v].id), TICK_W'(vecs[v].dly));
      check($sformatf("t%0d_count", v), 32'(count_out), 32'(vecs[v].exp_cnt));
      check($sformatf("t%0d_full", v), 32'(full_out), 32'(vecs[v].exp_full));
      check($sformatf("t%0d_ovf", v), 32'(overflow_out), 32'(vecs[v].exp_ovf));
    end
    for (int i = 0; i < 16; i++) exp_q.push_back(ID_W'(20 + i));
    do_tick(1100);
    wait_idle("t_drain_done", 64);
    check("t_ovf_pulses", 32'(ovf_pulses), 32'd1);
    check("t_count_end", 32'(count_out), 32'd0);
    check("t_full_end", 32'(full_out), 32'd0);
    check("t_q_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: three due ids, ready low for 5 cycles
    cyc(); tickval = 2000;
    drive_op(0, 8'd1, 32'd10);
    drive_op(0, 8'd2, 32'd10);
    drive_op(0, 8'd7, 32'd10);
    cyc(); rif.resume_ready_in = 1'b0;
    exp_q.push_back(8'd1);
    exp_q.push_back(8'd2);
    exp_q.push_back(8'd7);
    do_tick(2010);
    repeat (5) @(negedge aclk);
    check("bp_valid_held", 32'(rif.resume_tasktimer_out), 32'd1);
    check("bp_id_held", 32'(rif.idtasktimer_out), 32'd1);
    cyc(); rif.resume_ready_in = 1'b1;
    wait_idle("bp_done", 64);
    check("bp_q_empty", 32'(exp_q.size()), 32'd0);
    check("bp_count", 32'(count_out), 32'd0);

    // Wrap: wake = 0xFFFFFFFE + 4 = 2
    cyc(); tickval = 32'hFFFF_FFFE;
    drive_op(0, 8'd9, 32'd4);
    do_tick(32'hFFFF_FFFF);
    wait_idle("w_scan_ff_done", 64);
    do_tick(32'd0);
    wait_idle("w_scan_0_done", 64);
    check("w_count_pre", 32'(count_out), 32'd1);
    exp_q.push_back(8'd9);
    do_tick(32'd2);
    wait_idle("w_scan_2_done", 64);
    check("w_q_empty", 32'(exp_q.size()), 32'd0);

    // Refresh then cancel
    cyc(); tickval = 3000;
    drive_op(0, 8'd5, 32'd10);
    drive_op(0, 8'd5, 32'd20);
    check("r_count_refresh", 32'(count_out), 32'd1);
    do_tick(3015);
    wait_idle("r_scan3015_done", 64);
    check("r_count_3015", 32'(count_out), 32'd1);
    drive_op(1, 8'd5, 32'd0);
    check("r_count_cancel", 32'(count_out), 32'd0);
    do_tick(3025);
    wait_idle("r_scan3025_done", 64);

    // Reset during offer
    cyc(); tickval = 4000; rif.resume_ready_in = 1'b0;
    drive_op(0, 8'd4, 32'd5);
    drive_op(0, 8'd8, 32'd5);
    do_tick(4005);
    begin
      int n = 0;
      @(negedge aclk);
      while (!rif.resume_tasktimer_out && (n < 40)) begin
        @(negedge aclk);
        n++;
      end
    end
    check("x_offer_valid", 32'(rif.resume_tasktimer_out), 32'd1);
    check("x_offer_id", 32'(rif.idtasktimer_out), 32'd4);
    #1 aresetn = 1'b0;
    #1;
    check("x_valid_async", 32'(rif.resume_tasktimer_out), 32'd0);
    check("x_count_async", 32'(count_out), 32'd0);
    cyc(); cyc();
    aresetn = 1'b1;
    rif.resume_ready_in = 1'b1;
    do_tick(4100);
    wait_idle("x_scan_after_done", 64);
    check("x_count_after", 32'(count_out), 32'd0);

    repeat (3) @(negedge aclk);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
